ws2812_serializer: RTL
======================

# ws2812_serializer

Serial line driver for a WS2812 LED strip. It pulls 8-bit colour segments from an upstream colour source (the fancy fader) through a trigger/data_request handshake. Each byte is sent MSB first as WS2812 high/low pulse pairs. After LEDS×3 bytes it holds the line low for the latch (reset) time. It sits between the colour generator and the strip's data pin.

## Interface
Parameters:
- LEDS, 128: number of LEDs per frame; the frame is LEDS×3 bytes.
- T0H, 4: clk cycles dout is high for a 0 bit.
- T0L, 10: clk cycles dout is low for a 0 bit.
- T1H, 8: clk cycles dout is high for a 1 bit.
- T1L, 6: clk cycles dout is low for a 1 bit.
- RESET_CYCLES, 600: clk cycles dout is held low after a frame (latch time).

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: synchronous reset, active-low (0 = reset).
- trigger, input, 1: source has a frame ready; sampled only in IDLE.
- color_in, input, 8: current byte from the source; valid whenever data_request is high.
- data_request, output, 1: one-cycle pulse. The byte is consumed this cycle and the source advances on the same edge.
- dout, output, 1: WS2812 data line.
- busy, output, 1: high from frame start until the latch period ends.

## Operation
- Parameter constraints: all timing parameters ≥ 1; T0H < T1H; LEDS ≥ 1.
- States:
  - IDLE: dout=0. If trigger=1: assert data_request, load color_in into shift register sr, set bit_cnt=7, set byte_cnt=0, go to HIGH.
  - HIGH: dout=1 for T1H cycles if sr[7] else T0H cycles, then go to LOW.
  - LOW: dout=0 for T1L cycles if sr[7] else T0L cycles. At the end of the phase:
    - If bit_cnt≠0: shift sr left, decrement bit_cnt, go to HIGH.
    - If bit_cnt=0 and byte_cnt<LEDS×3−1: the last LOW cycle asserts data_request, loads color_in into sr, sets bit_cnt=7, increments byte_cnt, goes to HIGH.
    - Else: go to LATCH.
  - LATCH: dout=0 for RESET_CYCLES cycles, then go to IDLE.
- Bytes are transmitted in arrival order. Colour ordering (GRB) is the source's responsibility.
- trigger is ignored outside IDLE. A trigger drop mid-frame does not abort the frame.
- If trigger is still high on return to IDLE, the next frame starts immediately.
- Exactly LEDS×3 data_request pulses occur per frame.
- busy = (state ≠ IDLE).
- Phase counter width: $clog2 of max(T0H, T0L, T1H, T1L, RESET_CYCLES) + 1. byte_cnt width: $clog2(LEDS×3). Counter arithmetic never wraps within a frame.

## Timing
- Reset values: dout=0, data_request=0, busy=0, state=IDLE. All counters are cleared.
- Reset asserted mid-frame: on the next edge dout=0 and state=IDLE. No data_request is issued during reset.
- Latency: trigger high in IDLE → data_request high the same cycle (combinational from state and trigger). dout rises on the next edge.
- Bit period is exactly T0H+T0L or T1H+T1L cycles. Byte boundaries add no extra cycles, because the byte load overlaps the final LOW cycle.
- data_request is never asserted on two consecutive cycles. Minimum spacing between pulses is 8×min(bit period).
- Frame length: Σ bit periods + RESET_CYCLES + 1 IDLE cycle before the next trigger sample.

## Structure
- Shared package ws2812_pkg:
  - state enum (IDLE, HIGH, LOW, LATCH);
  - default timing constants for 12 MHz (T0H=4, T0L=10, T1H=8, T1L=6, RESET_CYCLES=600);
  - the bytes-per-LED constant 3.
- Optional sub-module ws2812_bit_timer: loadable down-counter with a done flag, shared by the HIGH, LOW and LATCH phases. The FSM, shift register and byte counter stay in the top module.

## Test plan
All scenarios use LEDS=1, T0H=2, T0L=4, T1H=4, T1L=2, RESET_CYCLES=10 unless noted.
- Reset: hold rst=0 with trigger=1 → dout=0, data_request=0, busy=0 throughout. Release rst → data_request pulses on the first cycle with rst=1.
- Bytes 0xA5, 0x00, 0xFF → dout pattern:
  - 0xA5 bits: 1 = 4 high + 2 low; 0 = 2 high + 4 low.
  - 0x00: all 0-bits.
  - 0xFF: all 1-bits.
  - Exactly 3 data_request pulses, spaced 48 cycles apart.
  - Then 10 low cycles; busy falls afterwards.
- Byte boundary: second data_request coincides with the final LOW cycle of bit 0 of byte 0. dout rises on the very next cycle (no gap).
- trigger dropped after the first data_request → frame still completes with 3 pulses. IDLE holds with dout=0 until trigger returns.
- trigger held high continuously → back-to-back frames. Each is separated by exactly 10 latch cycles + 1 IDLE cycle.
- rst=0 asserted mid-bit in byte 1 → next edge: dout=0, busy=0. After release with trigger=1, a fresh frame restarts at byte_cnt=0.

Source files
------------

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and constants for the WS2812 serial line driver.
//               Holds the FSM state encoding, default 12 MHz bit timing,
//               and a helper that sizes the phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

   // Line driver phases
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      LATCH = 2'd3
   } state_t;

   // Default WS2812 timing at a 12 MHz system clock (in clk cycles)
   localparam int c_T0H_12MHZ          = 4;
   localparam int c_T0L_12MHZ          = 10;
   localparam int c_T1H_12MHZ          = 8;
   localparam int c_T1L_12MHZ          = 6;
   localparam int c_RESET_CYCLES_12MHZ = 600;

   // Each LED takes one byte per colour channel (G, R, B)
   localparam int c_BYTES_PER_LED = 3;

   // Width of a down-counter able to hold the longest phase length.
   function automatic int phase_width(input int t0h, input int t0l,
                                      input int t1h, input int t1l,
                                      input int reset_cycles);
      int m;
      m = t0h;
      if (t0l > m) m = t0l;
      if (t1h > m) m = t1h;
      if (t1l > m) m = t1l;
      if (reset_cycles > m) m = reset_cycles;
      return $clog2(m) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_bit_timer
// Description : Loadable down-counter with a done flag. A phase of N cycles
//               is produced by loading N-1; done is high on the phase's last
//               cycle.
// Ports       : clk      - system clock
//               rst      - synchronous reset, active low
//               load     - load load_val into the counter this edge
//               load_val - phase length minus one
//               done     - counter has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_timer
   import ws2812_pkg::*;
#(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_serializer
// Description : WS2812 LED strip line driver. Pulls LEDS*3 bytes from an
//               upstream colour source via a trigger/data_request handshake,
//               sends each byte MSB first as high/low pulse pairs, then holds
//               the line low for the latch time.
// Ports       : clk          - system clock
//               rst          - synchronous reset, active low
//               trigger      - source has a frame ready (sampled in IDLE)
//               color_in     - current source byte, valid with data_request
//               data_request - one-cycle pulse, byte consumed this cycle
//               dout         - WS2812 data line
//               busy         - frame in progress (including latch time)
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_serializer
   import ws2812_pkg::*;
#(
   parameter int LEDS         = 128,
   parameter int T0H          = c_T0H_12MHZ,
   parameter int T0L          = c_T0L_12MHZ,
   parameter int T1H          = c_T1H_12MHZ,
   parameter int T1L          = c_T1L_12MHZ,
   parameter int RESET_CYCLES = c_RESET_CYCLES_12MHZ
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic [7:0] color_in,
   output logic       data_request,
   output logic       dout,
   output logic       busy
);

   localparam int c_TW    = phase_width(T0H, T0L, T1H, T1L, RESET_CYCLES);
   localparam int c_BYTES = LEDS * c_BYTES_PER_LED;
   localparam int c_BW    = $clog2(c_BYTES);

   // Timer load values are phase length minus one
   localparam logic [c_TW-1:0] c_T0H_LD   = c_TW'(T0H - 1);
   localparam logic [c_TW-1:0] c_T0L_LD   = c_TW'(T0L - 1);
   localparam logic [c_TW-1:0] c_T1H_LD   = c_TW'(T1H - 1);
   localparam logic [c_TW-1:0] c_T1L_LD   = c_TW'(T1L - 1);
   localparam logic [c_TW-1:0] c_LATCH_LD = c_TW'(RESET_CYCLES - 1);
   localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(c_BYTES - 1);

   state_t            r_state, w_next_state;
   logic [7:0]        r_sr, w_sr_next;
   logic [2:0]        r_bit_cnt, w_bit_cnt_next;
   logic [c_BW-1:0]   r_byte_cnt, w_byte_cnt_next;
   logic              r_dout;
   logic              w_req;
   logic              w_tmr_load;
   logic [c_TW-1:0]   w_tmr_val;
   logic              w_tmr_done;

   ws2812_bit_timer #(
      .WIDTH (c_TW)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .done     (w_tmr_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_dout     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_sr       <= w_sr_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_byte_cnt <= w_byte_cnt_next;
         // Registered decode keeps the data pin glitch-free
         r_dout     <= (w_next_state == HIGH);
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_sr_next       = r_sr;
      w_bit_cnt_next  = r_bit_cnt;
      w_byte_cnt_next = r_byte_cnt;
      w_req           = 1'b0;
      w_tmr_load      = 1'b0;
      w_tmr_val       = '0;

      case (r_state)
         IDLE: begin
            if (trigger) begin
               w_req           = 1'b1;
               w_sr_next       = color_in;
               w_bit_cnt_next  = 3'd7;
               w_byte_cnt_next = '0;
               w_tmr_load      = 1'b1;
               w_tmr_val       = color_in[7] ? c_T1H_LD : c_T0H_LD;
               w_next_state    = HIGH;
            end
         end

         HIGH: begin
            if (w_tmr_done) begin
               w_tmr_load   = 1'b1;
               w_tmr_val    = r_sr[7] ? c_T1L_LD : c_T0L_LD;
               w_next_state = LOW;
            end
         end

         LOW: begin
            if (w_tmr_done) begin
               if (r_bit_cnt != 3'd0) begin
                  // Next bit of the same byte; its high time depends on sr[6]
                  w_sr_next      = {r_sr[6:0], 1'b0};
                  w_bit_cnt_next = r_bit_cnt - 3'd1;
                  w_tmr_load     = 1'b1;
                  w_tmr_val      = r_sr[6] ? c_T1H_LD : c_T0H_LD;
                  w_next_state   = HIGH;
               end else if (r_byte_cnt < c_LAST_BYTE) begin
                  // Byte fetch overlaps the final low cycle: no gap on the line
                  w_req           = 1'b1;
                  w_sr_next       = color_in;
                  w_bit_cnt_next  = 3'd7;
                  w_byte_cnt_next = r_byte_cnt + c_BW'(1);
                  w_tmr_load      = 1'b1;
                  w_tmr_val       = color_in[7] ? c_T1H_LD : c_T0H_LD;
                  w_next_state    = HIGH;
               end else begin
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = c_LATCH_LD;
                  w_next_state = LATCH;
               end
            end
         end

         LATCH: begin
            if (w_tmr_done) begin
               w_next_state = IDLE;
            end
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // The request is combinational from state; mask it while reset is held
   assign data_request = w_req & rst;
   assign dout         = r_dout;
   assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire
